// File: rtl/binpool_2x2.sv
// 2x2 stride-2 OR-pool over a binary feature map held one row per SRAM word.
// Two source rows are fetched per pooled row; one pooled word is written every 4 cycles.
module binpool_2x2 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              pool_start,
  input  logic [4:0]        pool_dim,
  input  logic [ADDR_W-1:0] pool_src_base,
  input  logic [ADDR_W-1:0] pool_dst_base,
  output logic              pool_busy,
  output logic              pool_done,
  output logic [ADDR_W-1:0] pool_src_read_address,
  input  logic [DATA_W-1:0] src_pool_read_data,
  output logic [ADDR_W-1:0] pool_dst_write_address,
  output logic [DATA_W-1:0] pool_dst_write_data,
  output logic              pool_dst_write_enable
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LAT_B, WR, FIN} state_t;

  state_t            state_q, state_d;
  logic [4:0]        m_q, m_d, k_q, k_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0] row_a_q, row_a_d;
  logic              busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W/2-1:0] col_mask;
  logic [DATA_W-1:0] pooled;

  // Columns at or beyond M are forced to zero so stale high pixels never leak.
  always_comb begin
    col_mask = '0;
    pooled   = '0;
    for (int j = 0; j < DATA_W/2; j++) begin
      col_mask[j] = (5'(j) < m_q);
      pooled[j]   = col_mask[j] & (row_a_q[2*j] | row_a_q[2*j+1] |
                                   src_pool_read_data[2*j] | src_pool_read_data[2*j+1]);
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    k_d       = k_q;
    src_d     = src_q;
    dst_d     = dst_q;
    row_a_d   = row_a_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (pool_start) begin
        m_d   = 5'(pool_dim >> 1);
        k_d   = '0;
        src_d = pool_src_base;
        dst_d = pool_dst_base;
        if (pool_dim < 5'd2) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          state_d   = RD_A;
          busy_d    = 1'b1;
          rd_addr_d = pool_src_base;
        end
      end
      RD_A: begin
        state_d   = RD_B;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      RD_B: begin
        state_d = LAT_B;
        row_a_d = src_pool_read_data;
      end
      // Row B is consumed straight off the read bus to land the write in WR.
      LAT_B: begin
        state_d   = WR;
        we_d      = 1'b1;
        wr_addr_d = dst_q + ADDR_W'(k_q);
        wr_data_d = pooled;
      end
      WR: begin
        k_d = k_q + 5'd1;
        if (k_q == m_q - 5'd1) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d   = RD_A;
          rd_addr_d = src_q + ADDR_W'({k_d, 1'b0});
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      m_q       <= '0;
      k_q       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      row_a_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      k_q       <= k_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      row_a_q   <= row_a_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign pool_busy              = busy_q;
  assign pool_done              = done_q;
  assign pool_src_read_address  = rd_addr_q;
  assign pool_dst_write_address = wr_addr_q;
  assign pool_dst_write_data    = wr_data_q;
  assign pool_dst_write_enable  = we_q;

endmodule

// File: doc/binpool_2x2.md
Name: binpool_2x2

Overview:
- Downstream neighbour of the binary 3x3 convolution engine.
- Reads a binary feature map that the conv engine has left in the output SRAM: one 16-bit word per row, LSB-aligned, pixel c in bit c.
- Applies a 2x2 stride-2 OR-pool (binary max-pool).
- Writes the pooled rows to a destination SRAM region, one LSB-aligned word per pooled row.
- Processes one map per start pulse, with dimensions supplied by the sequencer.

Parameters:
- DATA_W, 16: SRAM word width; also the maximum map dimension.
- ADDR_W, 12: SRAM address width.

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- pool_start  in  1  one-cycle start request; sampled only in IDLE
- pool_dim  in  5  square map dimension N; sampled with pool_start; valid values are even numbers 0..16
- pool_src_base  in  ADDR_W  address of row 0 of the source map; sampled with pool_start
- pool_dst_base  in  ADDR_W  address of pooled row 0; sampled with pool_start
- pool_busy  out  1  high while a map is being processed
- pool_done  out  1  one-cycle pulse when a map completes
- pool_src_read_address  out  ADDR_W  source SRAM read address (registered)
- src_pool_read_data  in  DATA_W  source SRAM read data; valid the cycle after its address is presented
- pool_dst_write_address  out  ADDR_W  destination write address (registered)
- pool_dst_write_data  out  DATA_W  destination write data (registered)
- pool_dst_write_enable  out  1  destination write strobe (registered)

Behaviour:
- One clock. Reset is asynchronous and active-low on reset_b. All state and outputs are registered.
- Reset values: busy=0, done=0, write_enable=0, all addresses=0, write data=0, FSM=IDLE.
- Configuration:
  - N is latched at start; an odd N has its LSB ignored (floor to even).
  - M = N/2 pooled rows are produced, each M bits wide.
- FSM states: IDLE, RD_A, RD_B, LAT_B, WR, FIN.
  - IDLE: a pool_start sampled high latches the configuration and sets k=0.
    - If N<2, go to FIN with no reads or writes.
    - Otherwise go to RD_A and set busy=1 on the same edge.
  - RD_A: read address = src_base + 2k.
  - RD_B: read address = src_base + 2k + 1; row_a <= read data.
  - LAT_B: row_b <= read data.
  - WR:
    - write_enable=1 for exactly this cycle.
    - write address = dst_base + k.
    - write data bit j = row_a[2j] | row_a[2j+1] | row_b[2j] | row_b[2j+1] for j<M; bits j>=M are 0.
    - Then k++. If k==M-1 was just written, go to FIN; otherwise go to RD_A.
  - FIN: done=1 for one cycle and busy=0 from that cycle onward; next state IDLE.
- Timing:
  - Throughput is 4 cycles per pooled row.
  - Counting the start-sampling edge as cycle 0, the first write is in cycle 4 and the last write is in cycle 4M.
  - done is high in cycle 4M+1. For N<2, done is high in cycle 1.
- Address arithmetic is modulo 2^ADDR_W (wrap-around allowed).
- pool_start while not in IDLE is ignored; it does not restart or queue.
- write_enable is never high outside WR. Read data arriving in other states is ignored.
- Reset asserted mid-map: outputs return to reset values immediately, no further writes occur, and no done pulse is produced.
- The read address holds its last value in IDLE.

Test Plan:
- N=8, src_base=0x000, dst_base=0x040, rows 0..7 = 0x0001,0x0000,0x0080,0x0000,0x0000,0x0018,0xFFFF,0x0000 -> writes 0x001@0x040, 0x008@0x041, 0x006@0x042, 0x00F@0x043. write_enable high in cycles 4,8,12,16; done in cycle 17; busy high in cycles 1..16.
- N=14, all source rows 0x2AAA -> 7 writes of 0x007F at dst_base..dst_base+6. Bits 7..15 are 0.
- N=0 -> no reads change, no writes, done pulse in cycle 1, busy never set.
- pool_start re-pulsed in cycles 2 and 9 of an N=8 job -> ignored; exactly 4 writes and 1 done pulse.
- reset_b low in cycle 6 of an N=8 job -> busy, write_enable and addresses go to 0 immediately. No writes after reset is released until a new start.
- src_base=0xFFE, dst_base=0xFFF, N=4 -> reads 0xFFE,0xFFF,0x000,0x001; writes at 0xFFF then 0x000.
